// File: rtl/stat_bist_pkg.sv
// Shared types and constants for the Stat-class logic-BIST sequencer.
// Stat cores: 21 inputs, 24 outputs.
package stat_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int DEF_N_IN  = 21;
  localparam int DEF_N_OUT = 24;

  localparam int LFSR_TAP_A = 20;
  localparam int LFSR_TAP_B = 18;

  localparam logic [DEF_N_OUT-1:0] MISR_POLY =
    24'hC20001;

endpackage

// File: rtl/stat_bist_misr.sv
// Multiple-input signature register with clear and enable.
// Clear wins over enable; POLY selects the feedback taps.
module stat_bist_misr
  import stat_bist_pkg::*;
#(
  parameter int           W    = DEF_N_OUT,
  parameter logic [W-1:0] POLY = MISR_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sig_o
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_fb;

  assign w_fb  = r_sig[W-1] ? POLY : '0;
  assign sig_o = r_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (clr_i) begin
      r_sig <= '0;
    end else if (en_i) begin
      r_sig <= {r_sig[W-2:0], 1'b0} ^ w_fb ^ d_i;
    end
  end

endmodule

// File: rtl/stat_bist_ctrl.sv
// LFSR/MISR BIST sequencer for Stat-class cores.
// Optional BIST_SEED_LOAD_EN adds a seed_i port.
module stat_bist_ctrl
  import stat_bist_pkg::*;
#(
  parameter int               N_IN       = DEF_N_IN,
  parameter int               N_OUT      = DEF_N_OUT,
  parameter int               N_PATTERNS = 1024,
  parameter int               CORE_LAT   = 1,
  parameter logic [N_IN-1:0]  SEED       = 21'h000001,
  parameter logic [N_OUT-1:0] GOLDEN_SIG = 24'h000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
`ifdef BIST_SEED_LOAD_EN
  input  logic [N_IN-1:0]  seed_i,
`endif
  output logic [N_IN-1:0]  pat_o,
  output logic             pat_valid_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [N_OUT-1:0] sig_o
);

  localparam int CW = 17;
  localparam logic [CW-1:0] LAST = CW'(N_PATTERNS);

  state_t              r_state;
  logic [N_IN-1:0]     r_lfsr;
  logic [N_IN-1:0]     r_pat;
  logic                r_pat_valid;
  logic [CW-1:0]       r_cnt;
  logic [CORE_LAT-1:0] r_vpipe;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  logic [N_IN-1:0]  w_seed_raw;
  logic [N_IN-1:0]  w_seed;
  logic [N_IN-1:0]  w_lfsr_nxt;
  logic [N_OUT-1:0] w_sig;
  logic             w_abort;
  logic             w_go;
  logic             w_misr_en;

`ifdef BIST_SEED_LOAD_EN
  assign w_seed_raw = seed_i;
`else
  assign w_seed_raw = SEED;
`endif

  // An all-zero seed would lock the LFSR.
  assign w_seed = (w_seed_raw == '0) ?
                  N_IN'(1) : w_seed_raw;

  assign w_lfsr_nxt = {r_lfsr[N_IN-2:0],
                       r_lfsr[LFSR_TAP_A] ^
                       r_lfsr[LFSR_TAP_B]};

  assign w_abort = abort_i && (r_state != ST_IDLE);
  assign w_go    = start_i && !abort_i &&
                   ((r_state == ST_IDLE) ||
                    (r_state == ST_DONE));
  assign w_misr_en = r_vpipe[CORE_LAT-1] && !w_abort;

  stat_bist_misr #(
    .W    (N_OUT),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (w_go),
    .en_i  (w_misr_en),
    .d_i   (resp_i),
    .sig_o (w_sig)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lfsr      <= '0;
      r_pat       <= '0;
      r_pat_valid <= 1'b0;
      r_cnt       <= '0;
      r_vpipe     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_vpipe[0] <= r_pat_valid;
      for (int i = 1; i < CORE_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end
      if (w_abort) begin
        r_state     <= ST_IDLE;
        r_pat_valid <= 1'b0;
        r_vpipe     <= '0;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_pass      <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_go) begin
              r_state <= ST_SEED;
              r_lfsr  <= w_seed;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
          ST_SEED: begin
            r_state     <= ST_RUN;
            r_pat       <= r_lfsr;
            r_pat_valid <= 1'b1;
            r_cnt       <= CW'(1);
          end
          ST_RUN: begin
            if (r_cnt == LAST) begin
              r_state     <= ST_DRAIN;
              r_pat_valid <= 1'b0;
            end else begin
              r_lfsr <= w_lfsr_nxt;
              r_pat  <= w_lfsr_nxt;
              r_cnt  <= r_cnt + CW'(1);
            end
          end
          ST_DRAIN: begin
            if (r_vpipe == '0) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_sig == GOLDEN_SIG);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign pat_o       = r_pat;
  assign pat_valid_o = r_pat_valid;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign sig_o       = w_sig;

endmodule

// File: tb/tb_stat_bist_ctrl.sv
// Directed bench for stat_bist_ctrl: three instances
// (latency 1 golden 0/1, latency 3 with a core model).
module tb_stat_bist_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        abort_i;
  logic [23:0] r_resp;

  logic [20:0] pat0, pat1, pat3;
  logic        pv0, pv1, pv3;
  logic        bz0, bz1, bz3;
  logic        dn0, dn1, dn3;
  logic        ps0, ps1, ps3;
  logic [23:0] sg0, sg1, sg3;
  logic [23:0] d1, d2, d3;

  int n_vec;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] core_f(
    input logic [20:0] p);
    return {p[20:18], p} ^ 24'hA5A5A5;
  endfunction

  // Three-stage registered core for the latency-3 instance.
  always @(posedge clk) begin
    d1 <= core_f(pat3);
    d2 <= d1;
    d3 <= d2;
  end

  stat_bist_ctrl #(
    .N_PATTERNS (4),
    .CORE_LAT   (1),
    .GOLDEN_SIG (24'h000000)
  ) u0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
`ifdef BIST_SEED_LOAD_EN
    .seed_i      (21'h000001),
`endif
    .pat_o       (pat0),
    .pat_valid_o (pv0),
    .resp_i      (r_resp),
    .busy_o      (bz0),
    .done_o      (dn0),
    .pass_o      (ps0),
    .sig_o       (sg0)
  );

  stat_bist_ctrl #(
    .N_PATTERNS (4),
    .CORE_LAT   (1),
    .GOLDEN_SIG (24'h000001)
  ) u1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
`ifdef BIST_SEED_LOAD_EN
    .seed_i      (21'h000001),
`endif
    .pat_o       (pat1),
    .pat_valid_o (pv1),
    .resp_i      (r_resp),
    .busy_o      (bz1),
    .done_o      (dn1),
    .pass_o      (ps1),
    .sig_o       (sg1)
  );

  stat_bist_ctrl #(
    .N_PATTERNS (4),
    .CORE_LAT   (3),
    .GOLDEN_SIG (24'h000000)
  ) u3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
`ifdef BIST_SEED_LOAD_EN
    .seed_i      (21'h000001),
`endif
    .pat_o       (pat3),
    .pat_valid_o (pv3),
    .resp_i      (d3),
    .busy_o      (bz3),
    .done_o      (dn3),
    .pass_o      (ps3),
    .sig_o       (sg3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pat"},   32'(pat0), 0);
    chk({tag, "_pv"},    32'(pv0),  0);
    chk({tag, "_busy"},  32'(bz0),  0);
    chk({tag, "_done"},  32'(dn0),  0);
    chk({tag, "_pass"},  32'(ps0),  0);
    chk({tag, "_sig"},   32'(sg0),  0);
  endtask

  logic [20:0] e_pat;
  logic [23:0] prev3;
  int          nchg;

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    r_resp  = '0;
    tick();
    tick();
    chk_reset("rst");
    chk("rst_sig3", 32'(sg3), 0);
    rst_n = 1'b1;
    tick();

    // Run 1: resp 0, pattern order, latency, pass.
    start_pulse();
    chk("r1_seed_busy", 32'(bz0), 1);
    chk("r1_seed_pv",   32'(pv0), 0);
    prev3 = sg3;
    nchg  = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (sg3 !== prev3) nchg++;
      prev3 = sg3;
      if (k <= 4) begin
        e_pat = 21'd1 << (k - 1);
        chk("r1_pat", 32'(pat0), 32'(e_pat));
        chk("r1_pv",  32'(pv0),  1);
      end
      if (k == 5) begin
        chk("r1_hold", 32'(pat0), 32'h8);
        chk("r1_pv0",  32'(pv0),  0);
        chk("r1_drn",  32'(bz0),  1);
      end
      if (k == 6) chk("r1_early", 32'(dn0), 0);
      if (k == 7) begin
        chk("r1_done",  32'(dn0), 1);
        chk("r1_busy0", 32'(bz0), 0);
        chk("r1_sig",   32'(sg0), 0);
        chk("r1_pass",  32'(ps0), 1);
        chk("r1_pass1", 32'(ps1), 0);
      end
      if (k == 8) chk("l3_early", 32'(dn3), 0);
      if (k == 9) begin
        chk("l3_done", 32'(dn3), 1);
        chk("l3_sig",  32'(sg3), 32'h9F5556);
        chk("l3_pass", 32'(ps3), 0);
      end
    end
    chk("l3_nupd", 32'(nchg), 4);
    tick();
    chk("r1_keep", 32'(dn0), 1);
    chk("r1_keepp", 32'(ps0), 1);

    // Run 2: resp 1, signature progression.
    r_resp = 24'h000001;
    start_pulse();
    chk("r2_clr3", 32'(sg3), 0);
    chk("r2_dclr", 32'(dn0), 0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 3) chk("r2_s1", 32'(sg0), 32'h1);
      if (k == 4) chk("r2_s2", 32'(sg0), 32'h3);
      if (k == 5) chk("r2_s3", 32'(sg0), 32'h7);
      if (k == 6) chk("r2_s4", 32'(sg0), 32'hF);
      if (k == 7) begin
        chk("r2_done", 32'(dn0), 1);
        chk("r2_sig",  32'(sg0), 32'hF);
        chk("r2_pass", 32'(ps0), 0);
      end
    end

    // Run 3: abort in second RUN cycle, then rerun.
    start_pulse();
    tick();
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_pv",   32'(pv0), 0);
    chk("ab_done", 32'(dn0), 0);
    chk("ab_busy", 32'(bz0), 0);
    tick();
    tick();
    chk("ab_idle", 32'(bz0), 0);
    chk("ab_idlp", 32'(pv0), 0);
    start_pulse();
    for (int k = 1; k <= 7; k++) tick();
    chk("ab_rdone", 32'(dn0), 1);
    chk("ab_rsig",  32'(sg0), 32'hF);

    // Run 4: reset pulse in DRAIN.
    start_pulse();
    for (int k = 1; k <= 5; k++) tick();
    chk("rd_drain", 32'(bz0), 1);
    rst_n = 1'b0;
    tick();
    chk_reset("rd");
    rst_n = 1'b1;
    tick();

    // Run 5: start during RUN is ignored.
    start_pulse();
    tick();
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ig_p3", 32'(pat0), 32'h4);
    tick();
    chk("ig_p4", 32'(pat0), 32'h8);
    tick();
    chk("ig_pv", 32'(pv0), 0);
    tick();
    chk("ig_early", 32'(dn0), 0);
    tick();
    chk("ig_done", 32'(dn0), 1);
    chk("ig_sig",  32'(sg0), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stat_bist_ctrl.md
Name: stat_bist_ctrl

Overview:
Logic-BIST sequencer for the 21-input / 24-output Stat-class combinational benchmark cores. It drives core inputs from an LFSR and compacts the core outputs into a MISR. At end of run it compares the signature against a golden value. It sits beside the core in the benchmark wrapper; the core itself is instantiated outside this block.

Parameters:
N_IN, 21, core input width (pattern width)
N_OUT, 24, core output width (MISR width)
N_PATTERNS, 1024, patterns applied per run (1..2^16)
CORE_LAT, 1, cycles from pat_o change to valid resp_i (1..4)
SEED, 21'h000001, LFSR seed when BIST_SEED_LOAD_EN is undefined
GOLDEN_SIG, 24'h000000, expected final signature

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous, active-low reset
start_i  in  1  start pulse; accepted only in IDLE or DONE
abort_i  in  1  abort the run; return to IDLE next cycle
pat_o  out  N_IN  pattern driven to core inputs (registered)
pat_valid_o  out  1  pat_o holds a live pattern
resp_i  in  N_OUT  core outputs
busy_o  out  1  high in SEED/RUN/DRAIN
done_o  out  1  high in DONE
pass_o  out  1  valid when done_o: sig_o == GOLDEN_SIG
sig_o  out  N_OUT  current MISR contents

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; pat_o=0, pat_valid_o=0, busy_o=0, done_o=0, pass_o=0, sig_o=0; pattern and drain counters 0. rst_n low mid-run discards the run with no partial result.
- States: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE/DONE + start_i -> SEED. In the same edge: MISR=0, lfsr=seed (a zero seed is forced to 1), pattern count=0, done_o/pass_o cleared.
- SEED (1 cycle) -> RUN. On exit: pat_o=lfsr, pat_valid_o=1, count=1.
- RUN, each cycle:
  - lfsr_next = {lfsr[19:0], lfsr[20]^lfsr[18]}; pat_o follows lfsr_next.
  - When count==N_PATTERNS, pat_o holds its value, pat_valid_o drops and the block moves to DRAIN.
- Response sampling: a 1-bit valid pipe of depth CORE_LAT follows pat_valid_o. Whenever the pipe output is 1, misr_next = {misr[22:0],1'b0} ^ (misr[23] ? 24'hC20001 : 0) ^ resp_i (polynomial x^24+x^23+x^22+x^17+1). Exactly N_PATTERNS responses are compacted.
- DRAIN runs until the valid pipe is empty, which takes CORE_LAT cycles. It then goes to DONE and registers pass_o = (misr == GOLDEN_SIG).
- DONE holds sig_o, pass_o and done_o until the next start_i or reset.
- abort_i in any non-IDLE state -> IDLE next edge. pat_valid_o=0 and the valid pipe is flushed; sig_o keeps its value, done_o=0. abort_i beats start_i when both are high on the same cycle.
- start_i in SEED/RUN/DRAIN is ignored.
- Total run latency from start_i to done_o is 1 + N_PATTERNS + CORE_LAT + 1 cycles.

Optional Feature:
BIST_SEED_LOAD_EN
- Defined: adds input port seed_i[N_IN-1:0], sampled on the start_i edge and used as the seed (zero forced to 1).
- Undefined: no seed_i port; the SEED parameter is used.

Decomposition:
- Package stat_bist_pkg holds:
  - state enum (IDLE, SEED, RUN, DRAIN, DONE)
  - LFSR tap constants (20, 18)
  - MISR polynomial constant 24'hC20001
  - default widths 21/24
- One natural sub-module: stat_bist_misr, the N_OUT-bit MISR with enable, clear and polynomial parameter. It can be reused for other Stat cores.

Test Plan:
- Seed 21'h000001, N_PATTERNS=4, CORE_LAT=1: pat_o sequence 000001, 000002, 000004, 000008 on consecutive cycles. done_o rises exactly 7 cycles after start_i.
- resp_i tied 0, GOLDEN_SIG=0: sig_o=0 and pass_o=1 at done_o. Then GOLDEN_SIG=24'h000001 on the same stimulus: pass_o=0.
- resp_i = 24'h000001 for all 4 patterns, misr from 0: compaction runs 000001 -> 000003 -> 000007 -> 00000F. Final sig_o = 24'h00000F.
- abort_i asserted in cycle 2 of RUN: next cycle state=IDLE, pat_valid_o=0, done_o=0. A following start_i completes a normal run with the identical signature.
- rst_n low for 1 cycle mid-DRAIN: all outputs read their reset values next cycle. start_i during RUN is ignored; pattern count is unchanged.
- CORE_LAT=3 with a golden model of the core's 24-bit function: exactly N_PATTERNS MISR updates occur, the final sig_o matches the model, and done_o latency = N_PATTERNS+5.
